// File: rtl/tx_mac_pkg.sv
// Shared tx_mac definitions: AXIS width defaults and arbiter states.
// Imported by the tx-side arbiter and its picker.
package tx_mac_pkg;

   localparam int DEF_AXIS_DATA_WIDTH = 32;
   localparam int DEF_AXIS_DATA_BYTES = DEF_AXIS_DATA_WIDTH / 8;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_PASS = 1'b1
   } arb_state_t;

endpackage

// File: rtl/tx_axis_arb_pick.sv
// Combinational round-robin picker with optional strict priority for req[0].
// Produces a one-hot winner; all-zero when nothing is requesting.
module rr_arb_pick
   import tx_mac_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int PTR_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PTR_W-1:0]     rr_ptr,
   input  logic                 prio_en,
   output logic [NUM_PORTS-1:0] win
);

   logic [PTR_W:0] pos;
   logic           found;

   always_comb begin
      win   = '0;
      found = 1'b0;
      pos   = '0;
      if (prio_en && req[0]) begin
         win[0] = 1'b1;
      end else begin
         // scan upward from rr_ptr, wrapping; port 0 sits out under priority
         for (int i = 0; i < NUM_PORTS; i++) begin
            pos = {1'b0, rr_ptr} + (PTR_W+1)'(i);
            if (pos >= (PTR_W+1)'(NUM_PORTS))
               pos = pos - (PTR_W+1)'(NUM_PORTS);
            if (!found && req[pos[PTR_W-1:0]] &&
                !(prio_en && pos == '0)) begin
               win[pos[PTR_W-1:0]] = 1'b1;
               found               = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/tx_axis_arb.sv
// Frame-level AXIS arbiter in front of tx_mac: one grant per frame,
// released on the accepted tlast beat; round-robin with optional port-0 priority.
module tx_axis_arb
   import tx_mac_pkg::*;
#(
   parameter int NUM_PORTS       = 2,
   parameter int AXIS_DATA_WIDTH = DEF_AXIS_DATA_WIDTH,
   parameter int AXIS_DATA_BYTES = AXIS_DATA_WIDTH / 8,
   parameter int PRIO_PORT0      = 0
) (
   input  logic                                 tx_clk,
   input  logic                                 tx_rst,
   input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] in_req_tdata,
   input  logic [NUM_PORTS*AXIS_DATA_BYTES-1:0] in_req_tkeep,
   input  logic [NUM_PORTS-1:0]                 in_req_tvalid,
   input  logic [NUM_PORTS-1:0]                 in_req_tlast,
   output logic [NUM_PORTS-1:0]                 out_req_tready,
   output logic [AXIS_DATA_WIDTH-1:0]           out_master_tx_tdata,
   output logic [AXIS_DATA_BYTES-1:0]           out_master_tx_tkeep,
   output logic                                 out_master_tx_tvalid,
   output logic                                 out_master_tx_tlast,
   input  logic                                 in_master_tx_tready,
   output logic [NUM_PORTS-1:0]                 out_grant,
   output logic                                 out_busy
);

   localparam int PTR_W = $clog2(NUM_PORTS);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_PORTS - 1);

   arb_state_t                 state, state_nxt;
   logic [NUM_PORTS-1:0]       grant, grant_nxt;
   logic [PTR_W-1:0]           rr_ptr, rr_ptr_nxt;
   logic [NUM_PORTS-1:0]       win;
   logic [PTR_W-1:0]           g_idx;
   logic                       prio_en;
   logic                       pass;
   logic                       last_acc;
   logic [AXIS_DATA_WIDTH-1:0] mux_tdata;
   logic [AXIS_DATA_BYTES-1:0] mux_tkeep;
   logic                       mux_tvalid;
   logic                       mux_tlast;

   assign prio_en = (PRIO_PORT0 != 0);
   assign pass    = (state == ARB_PASS);

   rr_arb_pick #(
      .NUM_PORTS (NUM_PORTS),
      .PTR_W     (PTR_W)
   ) u_pick (
      .req     (in_req_tvalid),
      .rr_ptr  (rr_ptr),
      .prio_en (prio_en),
      .win     (win)
   );

   // grant is one-hot or zero, so the mux is a plain select
   always_comb begin
      mux_tdata  = '0;
      mux_tkeep  = '0;
      mux_tvalid = 1'b0;
      mux_tlast  = 1'b0;
      g_idx      = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant[i]) begin
            mux_tdata  = in_req_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
            mux_tkeep  = in_req_tkeep[i*AXIS_DATA_BYTES +: AXIS_DATA_BYTES];
            mux_tvalid = in_req_tvalid[i];
            mux_tlast  = in_req_tlast[i];
            g_idx      = PTR_W'(i);
         end
      end
   end

   assign out_master_tx_tdata  = mux_tdata;
   assign out_master_tx_tkeep  = mux_tkeep;
   assign out_master_tx_tvalid = pass & mux_tvalid;
   assign out_master_tx_tlast  = pass & mux_tlast;
   assign out_req_tready       = pass ? (grant & {NUM_PORTS{in_master_tx_tready}}) : '0;
   assign out_grant            = grant;
   assign out_busy             = pass;

   assign last_acc = out_master_tx_tvalid & in_master_tx_tready & out_master_tx_tlast;

   always_comb begin
      state_nxt  = state;
      grant_nxt  = grant;
      rr_ptr_nxt = rr_ptr;
      unique case (state)
         ARB_IDLE: begin
            if (|in_req_tvalid) begin
               state_nxt = ARB_PASS;
               grant_nxt = win;
            end
         end
         ARB_PASS: begin
            if (last_acc) begin
               state_nxt = ARB_IDLE;
               grant_nxt = '0;
               // priority grants to port 0 leave the rotation untouched
               if (!(prio_en && g_idx == '0))
                  rr_ptr_nxt = (g_idx == LAST_IDX) ? '0 : g_idx + PTR_W'(1);
            end
         end
         default: begin
            state_nxt = ARB_IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge tx_clk or posedge tx_rst) begin
      if (tx_rst) begin
         state  <= ARB_IDLE;
         grant  <= '0;
         rr_ptr <= '0;
      end else begin
         state  <= state_nxt;
         grant  <= grant_nxt;
         rr_ptr <= rr_ptr_nxt;
      end
   end

endmodule

// File: doc/tx_axis_arb.md
Name: tx_axis_arb

Overview:
- Frame-level arbiter that shares the single AXI-Stream slave of tx_mac between NUM_PORTS transmit requesters, for example the user datapath and a pause/control frame generator.
- Grants one requester at a time and holds the grant until that frame's tlast beat is accepted.
- Selection is round-robin, with optional strict priority for port 0.
- Sits directly upstream of tx_mac in the tx_clk domain; the output bundle connects 1:1 to tx_mac's in_slave_tx_* ports.

Parameters:
- NUM_PORTS, 2: number of requesting AXIS streams (2..8).
- AXIS_DATA_WIDTH, 32: tdata width per stream.
- AXIS_DATA_BYTES, AXIS_DATA_WIDTH/8: tkeep width per stream.
- PRIO_PORT0, 0: 1 means port 0 has strict priority over round-robin among the others; 0 means pure round-robin.

Ports:
- tx_clk  in  1  transmit clock; all logic is in this domain.
- tx_rst  in  1  asynchronous, active-high reset.
- in_req_tdata  in  NUM_PORTS*AXIS_DATA_WIDTH  flattened tdata; port i occupies [i*W +: W].
- in_req_tkeep  in  NUM_PORTS*AXIS_DATA_BYTES  flattened tkeep.
- in_req_tvalid  in  NUM_PORTS  per-port tvalid.
- in_req_tlast  in  NUM_PORTS  per-port tlast.
- out_req_tready  out  NUM_PORTS  per-port tready.
- out_master_tx_tdata  out  AXIS_DATA_WIDTH  to tx_mac in_slave_tx_tdata.
- out_master_tx_tkeep  out  AXIS_DATA_BYTES  to tx_mac in_slave_tx_tkeep.
- out_master_tx_tvalid  out  1  to tx_mac in_slave_tx_tvalid.
- out_master_tx_tlast  out  1  to tx_mac in_slave_tx_tlast.
- in_master_tx_tready  in  1  from tx_mac out_slave_tx_tready.
- out_grant  out  NUM_PORTS  one-hot current grant; all-zero when idle.
- out_busy  out  1  high while a frame is granted.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, grant = 0, rr_ptr = 0.
  - All outputs are 0: out_req_tready, out_master_tx_*, out_grant, out_busy.
- FSM states: IDLE and PASS.
- IDLE:
  - If any in_req_tvalid is high, compute the winner. Next cycle: state = PASS and the grant register holds the one-hot winner.
  - Otherwise remain in IDLE.
  - In IDLE, out_master_tx_tvalid and all out_req_tready are 0.
- Winner selection:
  - PRIO_PORT0=1 and in_req_tvalid[0] high: port 0 wins.
  - Otherwise: the first valid port scanning upward from rr_ptr, wrapping at NUM_PORTS-1 → 0.
  - When PRIO_PORT0=1, port 0 is excluded from the round-robin scan.
- PASS:
  - Output bundle is a combinational mux of the granted port (zero added latency per beat).
  - out_req_tready[g] = in_master_tx_tready; every other port's tready = 0.
  - tvalid deasserting mid-frame holds the grant; no timeout.
- Frame end:
  - A beat is accepted when out_master_tx_tvalid & in_master_tx_tready & out_master_tx_tlast.
  - Next cycle: state = IDLE, grant = 0.
  - rr_ptr = (g+1) mod NUM_PORTS. Port 0 grants under PRIO_PORT0=1 do not advance rr_ptr.
- Timing: exactly one IDLE bubble cycle between frames. This is acceptable because tx_mac inserts IFG.
  - Latency from a tvalid rise in IDLE to the first possible out_master_tx_tvalid: 1 cycle.
- Single-beat frame (tlast on the first beat): accepted in one PASS cycle, then IDLE.
- Simultaneous requests in IDLE: exactly one grant. Losers wait with tready = 0; their data is untouched.
- A requester dropping tvalid in IDLE before its grant is a protocol violation by the source. If the grant is issued anyway, the arbiter waits in PASS.
- Reset mid-frame: immediate return to IDLE, all outputs 0. No beats are emitted after reset deassertion until a new arbitration.
- out_busy = (state == PASS). out_grant = grant register.

Decomposition:
- Shared package tx_mac_pkg holds:
  - AXIS_DATA_WIDTH and AXIS_DATA_BYTES defaults;
  - the arbiter state encoding (ARB_IDLE, ARB_PASS).
- One sub-module, rr_arb_pick: a combinational round-robin picker.
  - Inputs: request vector, rr_ptr, priority enable.
  - Output: one-hot winner.
  - Reusable for rx-side scheduling.
- Top module holds the FSM, grant register, rr_ptr, and data mux.

Test Plan:
- Single port:
  - Stimulus: port 1 sends a 3-beat frame 0x11111111, 0x22222222, 0x33333333 with tkeep = 0xF, tready held at 1.
  - Response: out_grant = 2'b10 one cycle after tvalid; the three beats appear in order; tlast is on beat 3; out_busy falls the following cycle.
- Contention, round-robin (PRIO_PORT0=0, NUM_PORTS=2):
  - Stimulus: both ports continuously offer 2-beat frames.
  - Response: grants alternate 0, 1, 0, 1; one idle cycle between frames; no interleaving of beats.
- Strict priority (PRIO_PORT0=1, NUM_PORTS=3):
  - Stimulus: ports 0, 1 and 2 all valid; port 0 sends 2 frames back-to-back.
  - Response: the grant sequence is 0, 0, 1, 2.
- Backpressure:
  - Stimulus: in_master_tx_tready toggles 1, 0, 0, 1 during a 4-beat frame with tkeep = 0x3 on the last beat.
  - Response: the granted port's tready mirrors in_master_tx_tready; data is held stable; the tkeep 0x3 beat is passed unchanged; the grant is released only after the tlast handshake.
- Mid-frame stall and reset:
  - Stimulus: the granted port drops tvalid for 5 cycles mid-frame, then tx_rst is pulsed for 2 cycles.
  - Response: the grant is held during the stall; on reset, all outputs are 0 asynchronously and rr_ptr = 0; the next request is arbitrated fresh.
